// File: rtl/bus_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_sched_pkg : shared types/constants for the round-robin bus sched. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_e;

  localparam int               DEST_W            = 8;
  localparam logic [DEST_W-1:0] BROADCAST_DEFAULT = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/bus_rr_sched_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_rr_sched_if : source-FIFO pop side and destination push side.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface bus_rr_sched_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 16
);

  logic [drvrs-1:0]              pndng;
  logic [drvrs-1:0][pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]              pop;
  logic [drvrs-1:0]              push;
  logic [drvrs-1:0][pckg_sz-1:0] D_push;

  // master = FIFO/port side, slave = the scheduler
  modport master (
    output pndng, D_pop,
    input  pop, push, D_push
  );

  modport slave (
    input  pndng, D_pop,
    output pop, push, D_push
  );

endinterface
`default_nettype wire

// File: rtl/bus_rr_sched_rr_picker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rr_picker : combinational round-robin search starting at last+1.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module rr_picker #(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0]         req,
  input  logic [$clog2(drvrs)-1:0] last,
  output logic                     any,
  output logic [$clog2(drvrs)-1:0] idx
);

  localparam int               IDX_W = $clog2(drvrs);
  localparam logic [IDX_W:0]   SLOTS = (IDX_W+1)'(drvrs);

  logic [IDX_W:0] slot;

  // One extra bit on slot lets the wrap work for non-power-of-two port counts
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int off = 1; off <= drvrs; off++) begin
      slot = {1'b0, last} + (IDX_W+1)'(off);
      if (slot >= SLOTS) begin
        slot = slot - SLOTS;
      end
      if (!any && req[slot[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = slot[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_rr_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bus_rr_sched : 3-cycle IDLE/POP/PUSH round-robin packet scheduler.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module bus_rr_sched
  import bus_sched_pkg::*;
#(
  parameter int                drvrs     = 4,
  parameter int                pckg_sz   = 16,
  parameter logic [DEST_W-1:0] broadcast = BROADCAST_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  bus_rr_sched_if.slave            bus,
  output logic [$clog2(drvrs)-1:0] gnt_id,
  output logic                     busy,
  output logic [7:0]               err_cnt
);

  localparam int IDX_W = $clog2(drvrs);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
  logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
  logic [pckg_sz-1:0] pkt_reg_q, pkt_reg_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;
  logic [DEST_W-1:0]  dest;
  logic [drvrs-1:0]   dest_mask;
  logic               dest_drop;

  rr_picker #(
    .drvrs (drvrs)
  ) u_rr_picker (
    .req  (bus.pndng),
    .last (last_gnt_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = POP;
      POP:     state_d = PUSH;
      PUSH:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_gnt starts at the top port so port 0 wins the first arbitration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_id_q   <= '0;
      last_gnt_q <= IDX_W'(drvrs - 1);
      pkt_reg_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      gnt_id_q   <= gnt_id_d;
      last_gnt_q <= last_gnt_d;
      pkt_reg_q  <= pkt_reg_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  always_comb begin
    gnt_id_d   = gnt_id_q;
    last_gnt_d = last_gnt_q;
    pkt_reg_d  = pkt_reg_q;
    err_cnt_d  = err_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_id_d   = pick_idx;
          last_gnt_d = pick_idx;
        end
      end
      POP:  pkt_reg_d = bus.D_pop[gnt_id_q];
      PUSH: begin
        if (dest_drop && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Destination decode from the captured packet, independent of live inputs
  always_comb begin
    dest      = pkt_reg_q[pckg_sz-1 -: DEST_W];
    dest_mask = '0;
    dest_drop = 1'b0;
    if (dest < DEST_W'(drvrs)) begin
      for (int i = 0; i < drvrs; i++) begin
        dest_mask[i] = (dest == DEST_W'(i));
      end
    end else if (dest == broadcast) begin
      for (int i = 0; i < drvrs; i++) begin
        dest_mask[i] = (IDX_W'(i) != gnt_id_q);
      end
    end else begin
      dest_drop = 1'b1;
    end
  end

  always_comb begin
    bus.pop  = '0;
    bus.push = '0;
    case (state_q)
      POP:     bus.pop[gnt_id_q] = 1'b1;
      PUSH:    bus.push = dest_mask;
      default: ;
    endcase
  end

  assign bus.D_push = {drvrs{pkt_reg_q}};
  assign gnt_id     = gnt_id_q;
  assign busy       = (state_q != IDLE);
  assign err_cnt    = err_cnt_q;

endmodule
`default_nettype wire
